// File: rtl/tbird_turn_signal_gen.sv
// Thunderbird tail-light sequencer: sequential-fill turn pattern, hazard flash
// and brake overlay, stepped by a clock prescaler so lamps run off the system clock.
module tbird_turn_signal_gen #(
  parameter int LAMPS = 3,
  parameter int DIV   = 1,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_sw,
  input  logic             right_sw,
  input  logic             hazard_sw,
  input  logic             brake,
  output logic [LAMPS-1:0] l_lamps,
  output logic [LAMPS-1:0] r_lamps,
  output logic [1:0]       mode
);

  localparam int STEP_W = $clog2(LAMPS + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LEFT   = 2'd1;
  localparam logic [1:0] RIGHT  = 2'd2;
  localparam logic [1:0] HAZARD = 2'd3;

  logic [DIV_W-1:0]  count;
  logic              tick;
  logic [1:0]        state, req, state_n;
  logic [STEP_W-1:0] step, step_n;
  logic              phase, phase_n;
  logic [LAMPS-1:0]  seq, l_n, r_n;

  assign tick = (count == DIV_W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (tick)
      count <= '0;
    else
      count <= count + DIV_W'(1);
  end

  always_comb begin
    req = IDLE;
    if (hazard_sw || (left_sw && right_sw))
      req = HAZARD;
    else if (left_sw)
      req = LEFT;
    else if (right_sw)
      req = RIGHT;
  end

  // Switches only matter on tick edges; between ticks everything holds.
  always_comb begin
    state_n = state;
    step_n  = step;
    phase_n = phase;
    if (tick) begin
      if (req != state) begin
        state_n = req;
        case (req)
          LEFT, RIGHT: begin step_n = STEP_W'(1); phase_n = 1'b0; end
          HAZARD:      begin step_n = '0;         phase_n = 1'b1; end
          default:     begin step_n = '0;         phase_n = 1'b0; end
        endcase
      end else begin
        case (state)
          LEFT, RIGHT:
            step_n = (step == STEP_W'(LAMPS)) ? '0 : step + STEP_W'(1);
          HAZARD:
            phase_n = ~phase;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    seq = '0;
    for (int i = 0; i < LAMPS; i++)
      seq[i] = (i < int'(step_n));
  end

  // Lamps are built from the next state so they change on the same edge as it.
  always_comb begin
    l_n = '0;
    r_n = '0;
    case (state_n)
      LEFT: begin
        l_n = seq;
        if (brake) r_n = '1;
      end
      RIGHT: begin
        r_n = seq;
        if (brake) l_n = '1;
      end
      HAZARD: begin
        l_n = {LAMPS{phase_n}};
        r_n = {LAMPS{phase_n}};
      end
      default: begin
        if (brake) begin
          l_n = '1;
          r_n = '1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      step    <= '0;
      phase   <= 1'b0;
      l_lamps <= '0;
      r_lamps <= '0;
      mode    <= IDLE;
    end else begin
      state   <= state_n;
      step    <= step_n;
      phase   <= phase_n;
      l_lamps <= l_n;
      r_lamps <= r_n;
      mode    <= state_n;
    end
  end

endmodule

// File: tb/tb_tbird_turn_signal_gen.sv
// Bench for tbird_turn_signal_gen: a LAMPS=3/DIV=1 instance driven from a vector
// table, and a LAMPS=4/DIV=4 instance checked against a small prescaler model.
module tb_tbird_turn_signal_gen;

  typedef struct {
    logic       left, right, hazard, brake;
    logic [2:0] l, r;
    logic [1:0] mode;
  } vec_t;

  typedef struct {
    logic [3:0] l, r;
    logic [1:0] mode;
    bit         is_b;
    int         idx;
  } exp_t;

  logic       clk, reset;
  logic       left_a, right_a, hazard_a, brake_a;
  logic       left_b, right_b, hazard_b, brake_b;
  logic [2:0] l_a, r_a;
  logic [3:0] l_b, r_b;
  logic [1:0] mode_a, mode_b;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  exp_t sb[$];

  tbird_turn_signal_gen #(.LAMPS(3), .DIV(1), .DIV_W(8)) dut_a (
    .clk(clk), .reset(reset), .left_sw(left_a), .right_sw(right_a),
    .hazard_sw(hazard_a), .brake(brake_a),
    .l_lamps(l_a), .r_lamps(r_a), .mode(mode_a)
  );

  tbird_turn_signal_gen #(.LAMPS(4), .DIV(4), .DIV_W(8)) dut_b (
    .clk(clk), .reset(reset), .left_sw(left_b), .right_sw(right_b),
    .hazard_sw(hazard_b), .brake(brake_b),
    .l_lamps(l_b), .r_lamps(r_b), .mode(mode_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_value(input string name, input int idx,
                             input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s #%0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  // Called at a posedge+1: pops the oldest expectation and compares it.
  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $display("[TB] FAIL scoreboard: queue empty, got nothing, expected an entry");
      return;
    end
    e = sb.pop_front();
    if (e.is_b) begin
      check_value("b_l_lamps", e.idx, l_b, e.l);
      check_value("b_r_lamps", e.idx, r_b, e.r);
      check_value("b_mode",    e.idx, {2'b00, mode_b}, {2'b00, e.mode});
    end else begin
      check_value("a_l_lamps", e.idx, {1'b0, l_a}, e.l);
      check_value("a_r_lamps", e.idx, {1'b0, r_a}, e.r);
      check_value("a_mode",    e.idx, {2'b00, mode_a}, {2'b00, e.mode});
    end
  endtask

  // Entered at a negedge: drives A, queues the expectation, checks after the edge.
  task automatic apply_stimulus(input vec_t v, input int idx);
    exp_t e;
    left_a   = v.left;
    right_a  = v.right;
    hazard_a = v.hazard;
    brake_a  = v.brake;
    e.l = {1'b0, v.l};
    e.r = {1'b0, v.r};
    e.mode = v.mode;
    e.is_b = 1'b0;
    e.idx  = idx;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   step_m;
    bit   in_left;

    // inputs:        L  R  H  B   l       r       mode
    for (int k = 0; k < 9; k++) begin
      logic [2:0] pat [4];
      pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111; pat[3] = 3'b000;
      vecs.push_back('{1, 0, 0, 0, pat[k % 4], 3'b000, 2'd1});
    end
    vecs.push_back('{0, 0, 0, 0, 3'b000, 3'b000, 2'd0});
    vecs.push_back('{0, 1, 0, 0, 3'b000, 3'b001, 2'd2});
    vecs.push_back('{0, 1, 0, 0, 3'b000, 3'b011, 2'd2});
    vecs.push_back('{1, 0, 0, 0, 3'b001, 3'b000, 2'd1});
    vecs.push_back('{1, 0, 0, 0, 3'b011, 3'b000, 2'd1});
    vecs.push_back('{1, 1, 0, 0, 3'b111, 3'b111, 2'd3});
    vecs.push_back('{1, 1, 0, 1, 3'b000, 3'b000, 2'd3});
    vecs.push_back('{0, 0, 1, 1, 3'b111, 3'b111, 2'd3});
    vecs.push_back('{0, 0, 1, 0, 3'b000, 3'b000, 2'd3});
    vecs.push_back('{0, 0, 0, 0, 3'b000, 3'b000, 2'd0});
    vecs.push_back('{0, 0, 0, 1, 3'b111, 3'b111, 2'd0});
    vecs.push_back('{1, 0, 0, 1, 3'b001, 3'b111, 2'd1});
    vecs.push_back('{1, 0, 0, 1, 3'b011, 3'b111, 2'd1});
    vecs.push_back('{1, 0, 0, 1, 3'b111, 3'b111, 2'd1});
    vecs.push_back('{1, 0, 0, 1, 3'b000, 3'b111, 2'd1});
    vecs.push_back('{1, 0, 0, 0, 3'b001, 3'b000, 2'd1});
    vecs.push_back('{0, 0, 0, 0, 3'b000, 3'b000, 2'd0});
    vecs.push_back('{0, 1, 0, 1, 3'b111, 3'b001, 2'd2});
    vecs.push_back('{0, 1, 0, 0, 3'b000, 3'b011, 2'd2});
    vecs.push_back('{0, 0, 0, 0, 3'b000, 3'b000, 2'd0});
    vecs.push_back('{1, 0, 0, 0, 3'b001, 3'b000, 2'd1});
    vecs.push_back('{1, 0, 0, 0, 3'b011, 3'b000, 2'd1});

    reset = 1'b1;
    {left_a, right_a, hazard_a, brake_a} = 4'b0;
    {left_b, right_b, hazard_b, brake_b} = 4'b0;
    #1;
    check_value("reset_l_a", 0, {1'b0, l_a}, 4'h0);
    check_value("reset_r_a", 0, {1'b0, r_a}, 4'h0);
    check_value("reset_mode_a", 0, {2'b00, mode_a}, 4'h0);
    check_value("reset_l_b", 0, l_b, 4'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] applying %0d table vectors to the 3-lamp instance", vecs.size());
    for (int k = 0; k < vecs.size(); k++)
      apply_stimulus(vecs[k], k);

    // Lamps now show 011 mid-sequence: reset must clear them without a clock edge.
    #2 reset = 1'b1;
    #1;
    check_value("async_reset_l", 0, {1'b0, l_a}, 4'h0);
    check_value("async_reset_mode", 0, {2'b00, mode_a}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    v = '{1, 0, 0, 0, 3'b001, 3'b000, 2'd1};
    apply_stimulus(v, 100);
    v = '{1, 0, 0, 0, 3'b011, 3'b000, 2'd1};
    apply_stimulus(v, 101);

    reset = 1'b1;
    #1;
    left_a = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] prescaled 4-lamp instance, left held with glitches between ticks");
    step_m  = 0;
    in_left = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      left_b = (c % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (c % 4 == 0) begin
        if (!in_left) begin
          in_left = 1'b1;
          step_m  = 1;
        end else begin
          step_m = (step_m == 4) ? 0 : step_m + 1;
        end
      end
      e.l    = 4'((1 << step_m) - 1);
      e.r    = 4'h0;
      e.mode = in_left ? 2'd1 : 2'd0;
      e.is_b = 1'b1;
      e.idx  = c;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_output();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
